// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between NUM_REQ requesters.
// Optional opcode legality check enabled by defining ALU_ARB_OPCHECK_EN.
module alu_share_arbiter #(
   parameter int WIDTH   = 32,
   parameter int OP_LEN  = 5,
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]  req_a,
   input  logic [NUM_REQ*WIDTH-1:0]  req_b,
   input  logic [NUM_REQ*OP_LEN-1:0] req_op,
   output logic [WIDTH-1:0]          alu_a,
   output logic [WIDTH-1:0]          alu_b,
   output logic [OP_LEN-1:0]         alu_op,
   input  logic [WIDTH-1:0]          alu_sum,
   input  logic [3:0]                alu_flags,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [WIDTH-1:0]          rsp_sum,
   output logic [3:0]                rsp_flags,
   output logic                      rsp_err,
   output logic                      busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t              state_reg, state_next;
   logic [ID_W-1:0]     ptr_reg;
   logic [WIDTH-1:0]    alu_a_reg, alu_b_reg;
   logic [OP_LEN-1:0]   alu_op_reg;
   logic [ID_W-1:0]     rsp_id_reg;
   logic [WIDTH-1:0]    rsp_sum_reg;
   logic [3:0]          rsp_flags_reg;
   logic                rsp_err_reg;

   logic                found;
   logic [ID_W-1:0]     winner;
   logic                accept;
   logic                op_illegal;

   // First valid requester at or after ptr, wrapping at NUM_REQ.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && req_valid[(int'(ptr_reg) + k) % NUM_REQ]) begin
            found  = 1'b1;
            winner = ID_W'((int'(ptr_reg) + k) % NUM_REQ);
         end
      end
   end

   assign accept = (state_reg == IDLE) && found;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign req_ready[gi] = accept && (winner == ID_W'(gi));
      end
   endgenerate

`ifdef ALU_ARB_OPCHECK_EN
   assign op_illegal = (alu_op_reg != OP_LEN'(1)) && (alu_op_reg != OP_LEN'(2));
`else
   assign op_illegal = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (found) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         ptr_reg       <= '0;
         alu_a_reg     <= '0;
         alu_b_reg     <= '0;
         alu_op_reg    <= '0;
         rsp_id_reg    <= '0;
         rsp_sum_reg   <= '0;
         rsp_flags_reg <= '0;
         rsp_err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            alu_a_reg  <= req_a[winner*WIDTH +: WIDTH];
            alu_b_reg  <= req_b[winner*WIDTH +: WIDTH];
            alu_op_reg <= req_op[winner*OP_LEN +: OP_LEN];
            rsp_id_reg <= winner;
            ptr_reg    <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
         end
         // Operands stayed stable through EXEC, so the ALU output is settled here.
         if (state_reg == EXEC) begin
            rsp_sum_reg   <= op_illegal ? '0 : alu_sum;
            rsp_flags_reg <= op_illegal ? 4'b0 : alu_flags;
            rsp_err_reg   <= op_illegal;
         end
      end
   end

   assign alu_a     = alu_a_reg;
   assign alu_b     = alu_b_reg;
   assign alu_op    = alu_op_reg;
   assign rsp_valid = (state_reg == RESP);
   assign rsp_id    = rsp_id_reg;
   assign rsp_sum   = rsp_sum_reg;
   assign rsp_flags = rsp_flags_reg;
   assign rsp_err   = rsp_err_reg;
   assign busy      = (state_reg != IDLE);

endmodule
